// File: rtl/queue_ctrl_pkg.sv
// Shared queue constants: default geometry and data width.
// Used by the controller, the decoder and the queue top level.
package queue_ctrl_pkg;

    localparam int Q_DEPTH = 8;
    localparam int Q_PTR_W = 3;
    localparam int DATA_W  = 8;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/queue_ctrl_onehot_dec.sv
// Pointer-to-one-hot decoder for the per-register write enables.
// Output is all zero when en is low.
module onehot_dec
    import queue_ctrl_pkg::*;
#(
    parameter int DEPTH = Q_DEPTH,
    parameter int PTR_W = Q_PTR_W
) (
    input  logic [PTR_W-1:0] idx,
    input  logic             en,
    output logic [DEPTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/queue_top.sv
// Queue top level: controller, DEPTH data registers, head read mux.
// Register contents are not reset; reset only makes them unreachable.
module queue_top
    import queue_ctrl_pkg::*;
#(
    parameter int DEPTH = Q_DEPTH,
    parameter int PTR_W = Q_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  data_t            din,
    output data_t            dout,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    logic [DEPTH-1:0] wr_en;
    logic [PTR_W-1:0] rd_sel;
    data_t            mem [DEPTH];

    queue_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .wr_en     (wr_en),
        .rd_sel    (rd_sel),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) mem[i] <= din;
        end
    end

    assign dout = mem[rd_sel];

endmodule

// File: rtl/queue_ctrl.sv
// Pointer/count sequencer for a register-file queue.
// Drives one-hot write enables and the head read select.
module queue_ctrl
    import queue_ctrl_pkg::*;
#(
    parameter int DEPTH = Q_DEPTH,
    parameter int PTR_W = Q_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic [DEPTH-1:0] wr_en,
    output logic [PTR_W-1:0] rd_sel,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             ovf;
    logic             udf;
    logic             push_ok;
    logic             pop_ok;
    logic             push_err;
    logic             pop_err;

    assign full  = (cnt == (PTR_W+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // Reset blocks both requests so wr_en stays quiet while rst is high.
    assign pop_ok   = pop & ~empty & ~rst;
    assign push_ok  = push & (~full | pop_ok) & ~rst;
    assign push_err = push & ~push_ok & ~rst;
    assign pop_err  = pop & ~pop_ok & ~rst;

    assign rd_sel    = rd_ptr;
    assign overflow  = ovf;
    assign underflow = udf;

    onehot_dec #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_dec (
        .idx    (wr_ptr),
        .en     (push_ok),
        .onehot (wr_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A fresh error wins over a same-cycle clear.
            ovf <= push_err | (ovf & ~clr_err);
            udf <= pop_err | (udf & ~clr_err);
        end
    end

endmodule

// File: tb/tb_queue_ctrl.sv
// Randomized bench for queue_ctrl against a queue-based reference model.
// queue_top runs in parallel on the same stimulus to check data order.
module tb_queue_ctrl;
    import queue_ctrl_pkg::*;

    localparam int DEPTH = Q_DEPTH;
    localparam int PTR_W = Q_PTR_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clr_err = 1'b0;
    data_t            din = '0;
    logic [DEPTH-1:0] wr_en;
    logic [PTR_W-1:0] rd_sel;
    logic [PTR_W:0]   count;
    logic             full, empty, overflow, underflow;
    data_t            t_dout;
    logic [PTR_W:0]   t_count;
    logic             t_full, t_empty, t_ovf, t_udf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents, accepted push/pop totals, sticky flags.
    data_t m_q[$];
    int    m_wtot = 0;
    int    m_rtot = 0;
    bit    m_ovf = 0;
    bit    m_udf = 0;

    always #5 clk = ~clk;

    queue_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .wr_en     (wr_en),
        .rd_sel    (rd_sel),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    queue_top #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_top (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .din       (din),
        .dout      (t_dout),
        .count     (t_count),
        .full      (t_full),
        .empty     (t_empty),
        .overflow  (t_ovf),
        .underflow (t_udf)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check combinational view, advance model.
    task automatic cyc(input bit p, input bit po, input bit c, input bit r,
                       input data_t d);
        bit          e_pop_ok, e_push_ok;
        int          sz;
        logic [31:0] e_wr;
        push = p; pop = po; clr_err = c; rst = r; din = d;
        @(negedge clk);
        sz = m_q.size();
        e_pop_ok  = po && sz > 0 && !r;
        e_push_ok = p && (sz < DEPTH || e_pop_ok) && !r;
        e_wr = e_push_ok ? (32'd1 << (m_wtot % DEPTH)) : 32'd0;
        check("wr_en", 32'(wr_en), e_wr);
        check("rd_sel", 32'(rd_sel), 32'(m_rtot % DEPTH));
        check("count", 32'(count), 32'(sz));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("empty", 32'(empty), 32'(sz == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
        check("top_count", 32'(t_count), 32'(sz));
        check("top_flags", {28'd0, t_full, t_empty, t_ovf, t_udf},
              {28'd0, sz == DEPTH, sz == 0, m_ovf, m_udf});
        if (sz > 0) check("head_data", 32'(t_dout), 32'(m_q[0]));
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_wtot = 0; m_rtot = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (e_pop_ok) begin
                void'(m_q.pop_front());
                m_rtot++;
            end
            if (e_push_ok) begin
                m_q.push_back(d);
                m_wtot++;
            end
            m_ovf = (p && !e_push_ok) ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_udf = (po && !e_pop_ok) ? 1'b1 : (c ? 1'b0 : m_udf);
        end
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 1, 8'h00);
        cyc(1, 1, 0, 1, 8'h00);
        // Fill: one-hot enables walk 0x01..0x80.
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, data_t'((i + 1) * 8'h11));
        // Push while full, then clear the sticky overflow.
        cyc(1, 0, 0, 0, 8'hAA);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);
        // Full with push and pop together.
        cyc(1, 1, 0, 0, 8'h99);
        cyc(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 0, 8'h00);
        // Underflow, then simultaneous push and pop on empty.
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h5A);
        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        // Interleaved traffic forcing the pointers to wrap.
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 0, 0, data_t'(8'hC0 + i));
            cyc(0, 1, 0, 0, 8'h00);
        end
        // Reset with five entries held and requests asserted.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, data_t'(8'h30 + i));
        cyc(1, 1, 0, 1, 8'hEE);
        cyc(0, 0, 0, 0, 8'h00);
        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(bit'($urandom_range(0, 99) < 55),
                bit'($urandom_range(0, 99) < 45),
                bit'($urandom_range(0, 99) < 8),
                bit'($urandom_range(0, 999) < 5),
                data_t'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
